// File: rtl/wash_cycle_timer.sv
// wash_cycle_timer: 1 s tick wash-phase sequencer with BCD countdown and per-second billing.
// Billing (debit, start qualification, HOLD, topup) is enabled by defining WASH_BILLING_EN.
module wash_cycle_timer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAL_W   = 11,
    parameter int FILL_S  = 10,
    parameter int WASH_S  = 60,
    parameter int RINSE_S = 30,
    parameter int SPIN_S  = 20,
    parameter int RATE    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_on,
    input  logic             i_start,
    input  logic [BAL_W-1:0] i_bal_in,
    input  logic             i_topup,
    input  logic [BAL_W-1:0] i_topup_amt,
    output logic [BAL_W-1:0] o_bal_out,
    output logic [3:0]       o_d3,
    output logic [3:0]       o_d2,
    output logic [3:0]       o_d1,
    output logic [3:0]       o_d0,
    output logic [2:0]       o_phase,
    output logic [7:0]       o_st_light,
    output logic             o_done,
    output logic             o_hold,
    output logic             o_tick
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] P_MAX = PW'(CLK_HZ - 1);
    localparam logic [13:0] TOT = 14'(FILL_S + WASH_S + RINSE_S + SPIN_S);
    localparam logic signed [BAL_W-1:0] RATE_B = BAL_W'(RATE);
    localparam logic signed [BAL_W-1:0] BAL_MAX = {1'b0, {(BAL_W-1){1'b1}}};
`ifdef WASH_BILLING_EN
    localparam bit BILL = 1'b1;
`else
    localparam bit BILL = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE = 3'd0, FILL, WASH, RINSE, SPIN, DONE, HOLD} phase_t;

    phase_t                  r_phase, r_saved, w_phase_n, w_adv;
    logic [PW-1:0]           r_presc, w_presc_n;
    logic [13:0]             r_rem, r_left, w_rem_n, w_left_n, w_dur;
    logic signed [BAL_W-1:0] r_bal, w_bal_d, w_bal_n;
    logic signed [BAL_W:0]   w_sum;
    logic                    w_run, w_wrap, w_short, w_tick, w_start_ok, w_show0;
    logic [3:0]              w_th, w_hu, w_te, w_un;
    logic [7:0]              w_light_n;

    assign o_phase   = r_phase;
    assign o_bal_out = r_bal;
    assign o_tick    = w_tick;

    always_comb begin
        w_run      = (r_phase >= FILL) && (r_phase <= SPIN) && i_on;
        w_wrap     = w_run && (r_presc == P_MAX);
        w_short    = BILL && (r_bal < RATE_B);
        w_tick     = w_wrap && !w_short;
        w_start_ok = i_start && (r_phase == IDLE || r_phase == DONE) &&
                     (!BILL || $signed(i_bal_in) >= RATE_B);
        w_adv      = phase_t'(r_phase + 3'd1);
        w_dur      = (w_adv == WASH)  ? 14'(WASH_S)  :
                     (w_adv == RINSE) ? 14'(RINSE_S) :
                     (w_adv == SPIN)  ? 14'(SPIN_S)  : 14'd0;
        // debit first, then the saturating topup on the debited value
        w_bal_d    = (BILL && w_tick) ? r_bal - RATE_B : r_bal;
        w_sum      = {w_bal_d[BAL_W-1], w_bal_d} + {1'b0, i_topup_amt};
        w_bal_n    = w_start_ok ? i_bal_in :
                     (!BILL || !i_topup) ? w_bal_d :
                     (w_sum[BAL_W] != w_sum[BAL_W-1]) ? BAL_MAX : w_sum[BAL_W-1:0];
        w_phase_n  = r_phase;
        w_presc_n  = r_presc;
        w_rem_n    = r_rem;
        w_left_n   = r_left;
        if (w_start_ok) begin
            w_phase_n = FILL;
            w_presc_n = '0;
            w_rem_n   = TOT;
            w_left_n  = 14'(FILL_S);
        end else if (r_phase == HOLD) begin
            if (r_bal >= RATE_B) begin
                w_phase_n = r_saved;
                w_presc_n = '0;
            end
        end else if (w_wrap && w_short) begin
            w_phase_n = HOLD;
        end else if (w_run) begin
            w_presc_n = w_wrap ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                w_rem_n   = r_rem - 14'd1;
                w_left_n  = (r_left == 14'd1) ? w_dur : r_left - 14'd1;
                w_phase_n = (r_left == 14'd1) ? w_adv : r_phase;
            end
        end
        w_light_n = (w_phase_n == IDLE) ? 8'hFF : (~(8'h01 << (w_phase_n - 3'd1)) | 8'hC0);
        w_show0   = (r_phase == IDLE) || (r_phase == DONE);
        w_th      = 4'(r_rem / 14'd1000);
        w_hu      = 4'((r_rem / 14'd100) % 14'd10);
        w_te      = 4'((r_rem / 14'd10) % 14'd10);
        w_un      = 4'(r_rem % 14'd10);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase    <= IDLE;
            r_saved    <= IDLE;
            r_presc    <= '0;
            r_rem      <= '0;
            r_left     <= '0;
            r_bal      <= '0;
            o_d3       <= 4'd11;
            o_d2       <= 4'd11;
            o_d1       <= 4'd11;
            o_d0       <= 4'd0;
            o_st_light <= 8'hFF;
            o_done     <= 1'b0;
            o_hold     <= 1'b0;
        end else begin
            r_phase    <= w_phase_n;
            r_saved    <= (r_phase != HOLD) ? r_phase : r_saved;
            r_presc    <= w_presc_n;
            r_rem      <= w_rem_n;
            r_left     <= w_left_n;
            r_bal      <= w_bal_n;
            o_d3       <= (w_show0 || w_th == 4'd0) ? 4'd11 : w_th;
            o_d2       <= (w_show0 || (w_th == 4'd0 && w_hu == 4'd0)) ? 4'd11 : w_hu;
            o_d1       <= (w_show0 || (w_th == 4'd0 && w_hu == 4'd0 && w_te == 4'd0)) ? 4'd11 : w_te;
            o_d0       <= w_show0 ? 4'd0 : w_un;
            o_st_light <= w_light_n;
            o_done     <= (w_phase_n == DONE);
            o_hold     <= (w_phase_n == HOLD);
        end
    end
endmodule

// File: tb/tb_wash_cycle_timer.sv
// tb_wash_cycle_timer: directed scoreboard bench for wash_cycle_timer (CLK_HZ=4, durations 1/2/1/1).
module tb_wash_cycle_timer;
    localparam int BW = 11;
`ifdef WASH_BILLING_EN
    localparam bit BILL = 1'b1;
`else
    localparam bit BILL = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b1, on = 1'b1, start = 1'b0, topup = 1'b0;
    logic [BW-1:0] bal_in = '0, topup_amt = '0;
    logic [BW-1:0] bal_out;
    logic [3:0]    d3, d2, d1, d0;
    logic [2:0]    phase;
    logic [7:0]    st_light;
    logic          done, hold, tick;

    typedef struct {int ph; int rem; int bal;} exp_t;
    exp_t sb[$];
    int   n_asrt = 0, n_fail = 0, cyc = 0, last_tick = 0, c_start = 0, pop_cyc = 0, cur_bal = 0;
    bit   hold_seen = 1'b0;

    wash_cycle_timer #(.CLK_HZ(4), .BAL_W(BW), .FILL_S(1), .WASH_S(2), .RINSE_S(1), .SPIN_S(1), .RATE(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_on(on), .i_start(start), .i_bal_in(bal_in),
        .i_topup(topup), .i_topup_amt(topup_amt), .o_bal_out(bal_out),
        .o_d3(d3), .o_d2(d2), .o_d1(d1), .o_d0(d0), .o_phase(phase), .o_st_light(st_light),
        .o_done(done), .o_hold(hold), .o_tick(tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (hold === 1'b1) hold_seen = 1'b1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] light(input int ph);
        logic [7:0] m;
        m = 8'hFF;
        if (ph != 0) m[ph-1] = 1'b0;
        return m;
    endfunction

    function automatic logic [15:0] dig(input int r);
        int a, b, c, e;
        a = (r < 1000) ? 11 : r / 1000;
        b = (r < 100) ? 11 : (r / 100) % 10;
        c = (r < 10) ? 11 : (r / 10) % 10;
        e = r % 10;
        return {4'(a), 4'(b), 4'(c), 4'(e)};
    endfunction

    task automatic push_ticks(input int rem0, input int b, input int n);
        exp_t e;
        int   el;
        for (int i = 0; i < n; i++) begin
            rem0--;
            if (BILL) b--;
            el    = 5 - rem0;
            e.rem = rem0;
            e.bal = b;
            e.ph  = (el >= 5) ? 5 : (el >= 4) ? 4 : (el >= 3) ? 3 : (el >= 1) ? 2 : 1;
            sb.push_back(e);
        end
    endtask

    task automatic start_cycle(input int b);
        bal_in = BW'(b);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_phase", {29'b0, phase}, 1);
        c_start   = cyc;
        last_tick = cyc - 1;
    endtask

    task automatic expect_tick(input int gap, input string tag);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_tick_seen"}, {31'b0, tick}, 1);
        chk({tag, "_tick_gap"}, cyc - last_tick, gap);
        last_tick = cyc;
        @(posedge clk); #1;
        pop_cyc = cyc;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        cur_bal = e.bal;
        chk({tag, "_phase"}, {29'b0, phase}, e.ph);
        chk({tag, "_bal"}, {21'b0, bal_out}, e.bal);
        chk({tag, "_done"}, {31'b0, done}, (e.ph == 5) ? 1 : 0);
        chk({tag, "_light"}, {24'b0, st_light}, {24'b0, light(e.ph)});
        @(posedge clk); #1;
        chk({tag, "_digits"}, {16'b0, d3, d2, d1, d0}, {16'b0, dig(e.rem)});
    endtask

    initial begin
        int n, tk;
        // reset: asserted between clock edges, checked before any edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_phase", {29'b0, phase}, 0);
        chk("rst_bal", {21'b0, bal_out}, 0);
        chk("rst_digits", {16'b0, d3, d2, d1, d0}, 32'h0000BBB0);
        chk("rst_light", {24'b0, st_light}, 32'hFF);
        chk("rst_flags", {29'b0, done, hold, tick}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_phase", {29'b0, phase}, 0);

`ifdef WASH_BILLING_EN
        // rejected start with no funds
        bal_in = '0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rej_phase", {29'b0, phase}, 0);
        @(posedge clk); #1;
        chk("rej_phase2", {29'b0, phase}, 0);
        chk("rej_bal", {21'b0, bal_out}, 0);
`else
        // without billing a zero balance still runs to DONE
        start_cycle(0);
        push_ticks(5, 0, 5);
        for (int i = 0; i < 5; i++) expect_tick(4, "off");
        chk("off_done_cycles", pop_cyc - c_start, 20);
        chk("off_bal_final", {21'b0, bal_out}, 0);
`endif

        // normal cycle with a 10-cycle freeze in WASH and a stray start in RINSE
        start_cycle(10);
        push_ticks(5, 10, 5);
        expect_tick(4, "norm_fill");
        on = 1'b0;
        tk = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tick === 1'b1) tk++;
            @(posedge clk);
        end
        #1 on = 1'b1;
        chk("frz_ticks", tk, 0);
        chk("frz_phase", {29'b0, phase}, 2);
        chk("frz_digits", {16'b0, d3, d2, d1, d0}, {16'b0, dig(4)});
        expect_tick(14, "norm_wash1");
        expect_tick(4, "norm_wash2");
        bal_in = BW'(100);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_start_phase", {29'b0, phase}, 3);
        chk("mid_start_bal", {21'b0, bal_out}, cur_bal);
        expect_tick(4, "norm_rinse");
        expect_tick(4, "norm_spin");
        chk("norm_final_bal", {21'b0, bal_out}, BILL ? 5 : 10);
        chk("norm_done_light", {24'b0, st_light}, 32'hEF);

`ifdef WASH_BILLING_EN
        // run out of funds in WASH, top up, resume
        start_cycle(2);
        push_ticks(5, 2, 2);
        expect_tick(4, "oof1");
        expect_tick(4, "oof2");
        n  = 0;
        tk = 0;
        while (hold !== 1'b1 && n < 20) begin
            @(negedge clk);
            if (tick === 1'b1) tk++;
            n++;
        end
        chk("oof_hold", {31'b0, hold}, 1);
        chk("oof_no_tick", tk, 0);
        chk("oof_phase", {29'b0, phase}, 6);
        chk("oof_bal", {21'b0, bal_out}, 0);
        chk("oof_digits", {16'b0, d3, d2, d1, d0}, {16'b0, dig(3)});
        chk("oof_light", {24'b0, st_light}, 32'hDF);
        @(posedge clk); #1;
        topup     = 1'b1;
        topup_amt = BW'(3);
        @(posedge clk); #1;
        topup = 1'b0;
        chk("topup_bal", {21'b0, bal_out}, 3);
        chk("topup_still_hold", {29'b0, phase}, 6);
        @(posedge clk); #1;
        chk("resume_phase", {29'b0, phase}, 2);
        chk("resume_hold", {31'b0, hold}, 0);
        last_tick = cyc - 1;
        push_ticks(3, 3, 3);
        for (int i = 0; i < 3; i++) expect_tick(4, "oof_resume");
        chk("oof_final_bal", {21'b0, bal_out}, 0);
`endif

        // asynchronous reset in the middle of RINSE
        start_cycle(10);
        push_ticks(5, 10, 5);
        for (int i = 0; i < 3; i++) expect_tick(4, "rr");
        #2 rst_n = 1'b0;
        #1;
        chk("rr_phase", {29'b0, phase}, 0);
        chk("rr_bal", {21'b0, bal_out}, 0);
        chk("rr_digits", {16'b0, d3, d2, d1, d0}, 32'h0000BBB0);
        chk("rr_light", {24'b0, st_light}, 32'hFF);
        chk("rr_tick", {31'b0, tick}, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rr_idle", {29'b0, phase}, 0);

`ifndef WASH_BILLING_EN
        chk("off_never_hold", {31'b0, hold_seen}, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/wash_cycle_timer.md
# wash_cycle_timer

Parametrised wash-cycle sequencer with per-second billing for the washing-machine controller. It divides the system clock to a 1 s tick and steps through the FILL, WASH, RINSE and SPIN phases, each with a configurable duration. It counts down the total remaining time as four BCD digits for the existing 4-digit scanner, and debits a signed balance every second, holding the cycle when funds run out. It sits between the coin/balance logic and the display scanner.

## Interface
- CLK_HZ, 100_000_000, clock cycles per 1 s tick (≥2)
- BAL_W, 11, signed balance width
- FILL_S / WASH_S / RINSE_S / SPIN_S, 10 / 60 / 30 / 20, phase durations in seconds, each ≥1, sum ≤9999
- RATE, 1, balance units debited per tick (≥1)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- on  in  1  run enable (level); low freezes the cycle
- start  in  1  one-cycle pulse, begins a cycle from IDLE/DONE
- bal_in  in  BAL_W  signed starting balance, sampled at accepted start
- topup  in  1  one-cycle pulse, add topup_amt to balance
- topup_amt  in  BAL_W  unsigned amount (MSB must be 0)
- bal_out  out  BAL_W  current signed balance
- d3, d2, d1, d0  out  4 each  BCD remaining seconds, d3 = thousands; 4'd11 = blank
- phase  out  3  IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 DONE=5 HOLD=6
- st_light  out  8  active-low phase LEDs: bit0 FILL, bit1 WASH, bit2 RINSE, bit3 SPIN, bit4 DONE, bit5 HOLD, bits7:6 always 1
- done  out  1  high while phase==DONE
- hold  out  1  high while phase==HOLD
- tick  out  1  one-cycle pulse per counted second

## Operation
- Reset values: phase=IDLE, bal_out=0, digits={11,11,11,0}, st_light=8'hFF, done=0, hold=0, tick=0, prescaler=0, remaining=0.
- IDLE/DONE + start: accepted if bal_in ≥ RATE. Then load balance←bal_in, remaining←total sum, phase_left←FILL_S, prescaler←0, and go to FILL. Otherwise start is ignored. start in any other state is ignored.
- Prescaler: $clog2(CLK_HZ)-bit counter, 0..CLK_HZ-1. It increments only in FILL..SPIN with on=1, and holds otherwise. A tick fires when it equals CLK_HZ-1 and it wraps to 0.
- On tick, if balance < RATE: go to HOLD, save the phase, make no decrement, and do not assert tick.
- On tick otherwise: remaining−1, phase_left−1, balance−RATE. If phase_left becomes 0, advance FILL→WASH→RINSE→SPIN→DONE and load the next duration.
- HOLD: the prescaler is frozen. Each topup adds topup_amt, saturating at the max positive value. When balance ≥ RATE, return to the saved phase on the next cycle with prescaler←0.
- topup is also accepted in every other state, with the same saturating add. A topup and a debit in the same cycle apply both, in the order debit then add.
- on=0 freezes phase, prescaler and counters. topup is still accepted.
- Digits: binary remaining → BCD, with leading zeros blanked to 11. d0 is never blanked. IDLE and DONE show "   0".
- st_light: all bits 1 in IDLE, one bit 0 for the current phase otherwise.

## Timing
- Accepted start → phase=FILL on the next edge.
- The tick cycle updates phase, remaining and bal_out at the same edge; tick is high during that cycle. Digits are registered and lag remaining by 1 cycle.
- First tick occurs CLK_HZ cycles after the FILL entry (when on stays high).
- Insufficient-funds detection → hold=1 on the next edge. Satisfying topup → HOLD exit after 1 further edge.
- Reset acts immediately and asynchronously at any point, including mid-cycle. Release is synchronous to the next rising edge.

## Configuration
- WASH_BILLING_EN defined: billing as above (debit, start qualification, HOLD, topup).
- WASH_BILLING_EN undefined:
  - start is always accepted.
  - balance←bal_in at start and is never modified.
  - topup is ignored.
  - HOLD is unreachable and hold/st_light[5] stay at their inactive values.

## Test plan
Bench parameters: CLK_HZ=4, FILL_S=1, WASH_S=2, RINSE_S=1, SPIN_S=1, RATE=1 (total 5).
- Normal cycle: bal_in=10, start → phases 1,2,2,3,4,5 at 4-cycle spacing; digits 5→0; final bal_out=5, done=1, st_light=8'b11101111.
- Out of funds: bal_in=2, start → after 2 ticks phase=6, remaining=3, bal_out=0. topup_amt=3 → resume; DONE with bal_out=0.
- Freeze: on=0 for 10 cycles in WASH → no tick, remaining and prescaler unchanged; resume completes on schedule.
- Rejected start: bal_in=0, start → phase stays 0, bal_out=0. start pulsed mid-RINSE → no effect.
- Reset mid-RINSE: rst=0 → asynchronously phase=0, bal_out=0, digits={11,11,11,0}, st_light=8'hFF.
- Macro off: bal_in=0, start → runs to DONE in 20 cycles, bal_out=0 throughout, hold never asserted.
